// File: rtl/ap_mult_pkg.sv
// Shared definitions for the approximate pipelined multiplier: latency,
// level saturation, the carry-save pair type and a reference model.
package ap_mult_pkg;

    localparam int LAT    = 3;
    localparam int MAX_PW = 64;

    // Carry-save pair sized for the widest product (WIDTH=32)
    typedef struct packed {
        logic [MAX_PW-1:0] sum;
        logic [MAX_PW-1:0] carry;
    } cs_pair_t;

    // Clamp the requested level to the top product column
    function automatic int sat_lvl(input int lvl, input int width);
        return (lvl > 2*width-1) ? 2*width-1 : lvl;
    endfunction

    // Column-by-column model: exact counts at or above k, OR below k
    function automatic logic [63:0] ap_mult_ref(input logic [31:0] a, input logic [31:0] b,
                                                input int k, input int width);
        logic [63:0] r;
        logic [63:0] cnt;
        int          kk;
        kk = sat_lvl(k, width);
        r  = '0;
        for (int c = 0; c < 2*width; c++) begin
            cnt = '0;
            for (int i = 0; i < width; i++) begin
                if (c-i >= 0 && c-i < width)
                    cnt += 64'(a[c-i] & b[i]);
            end
            if (c >= kk)
                r += cnt << c;
            else if (cnt != '0)
                r += 64'(1) << c;
        end
        return r;
    endfunction

endpackage

// File: rtl/ap_mult_pipe_col.sv
// One product column. Approximate columns collapse to an OR bit and emit no
// carries. Exact columns add their bits to the count arriving from the column
// below, keep bit 0 as the sum, bit 1 as the carry-save carry into the next
// column, and pass the remaining (even) count on up the chain.
module ap_col_compress #(
    parameter int H  = 12,
    parameter int CW = 5
) (
    input  logic [H-1:0]  bits,
    input  logic          is_approx,
    input  logic [CW-1:0] cin,
    output logic          sum_bit,
    output logic          carry_bit,
    output logic [CW-1:0] cout
);

    logic [CW-1:0] tot;

    // Column popcount plus incoming chain count, then split into sum/carry/chain
    always_comb begin
        tot = cin;
        for (int i = 0; i < H; i++)
            tot = tot + CW'(bits[i]);
        if (is_approx) begin
            sum_bit   = |bits;
            carry_bit = 1'b0;
            cout      = '0;
        end else begin
            sum_bit   = tot[0];
            carry_bit = tot[1];
            cout      = {1'b0, tot[CW-1:2], 1'b0};
        end
    end

endmodule

// File: rtl/ap_mult_pipe.sv
// Pipelined approximate unsigned multiplier with valid/ready on both sides.
// Columns below the captured level k are OR-compressed, the rest are exact.
// Optional feature macro: AP_MULT_ERR_MON_EN (exact-product error monitor).
module ap_mult_pipe
    import ap_mult_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int LVL_W = $clog2(2*WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [LVL_W-1:0]   in_lvl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_res,
    output logic [2*WIDTH-1:0] out_err,
    output logic [31:0]        err_cnt
);

    localparam int PW   = 2*WIDTH;
    localparam int NCOL = PW-1;
    localparam int CW   = $clog2(2*WIDTH+1);

    logic [LAT:1]     vld_pipe;
    logic             s1_open, s2_open, s3_open;
    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [LVL_W-1:0] s1_k, k_sat;
    cs_pair_t         cs_nxt, s2_cs;
    logic [PW-1:0]    res_nxt, s3_res;

    // A stage moves when it holds data and the stage ahead is free or draining
    assign s3_open  = !vld_pipe[3] || out_ready;
    assign s2_adv   = vld_pipe[2] && s3_open;
    assign s2_open  = !vld_pipe[2] || s2_adv;
    assign s1_adv   = vld_pipe[1] && s2_open;
    assign s1_open  = !vld_pipe[1] || s1_adv;
    assign in_ready = !rst && s1_open;

    assign out_valid = vld_pipe[3];
    assign out_res   = s3_res;
    assign k_sat     = LVL_W'(sat_lvl(int'(in_lvl), WIDTH));

    // Valid bits: each follows the stage behind it whenever it is open
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            if (s1_open) vld_pipe[1] <= in_valid;
            if (s2_open) vld_pipe[2] <= vld_pipe[1];
            if (s3_open) vld_pipe[3] <= vld_pipe[2];
        end
    end

    // S1: capture operands and the clamped level on a handshake only
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_a <= in_a;
            s1_b <= in_b;
            s1_k <= k_sat;
        end
    end

    // Partial-product columns and one compressor per column
    logic [NCOL-1:0][WIDTH-1:0] col_bits;
    logic [NCOL-1:0]            col_apx, col_sum, col_carry;
    logic [NCOL:0][CW-1:0]      col_cin;
    logic [CW-1:0]              unused_cout;

    assign col_cin[0]  = '0;
    assign unused_cout = col_cin[NCOL];

    for (genvar c = 0; c < NCOL; c++) begin : g_col
        for (genvar i = 0; i < WIDTH; i++) begin : g_pp
            localparam int J = c - i;
            if (J >= 0 && J < WIDTH) begin : g_on
                assign col_bits[c][i] = s1_a[J] & s1_b[i];
            end else begin : g_off
                assign col_bits[c][i] = 1'b0;
            end
        end
        assign col_apx[c] = (c < int'(s1_k));
        ap_col_compress #(.H(WIDTH), .CW(CW)) u_col (
            .bits      (col_bits[c]),
            .is_approx (col_apx[c]),
            .cin       (col_cin[c]),
            .sum_bit   (col_sum[c]),
            .carry_bit (col_carry[c]),
            .cout      (col_cin[c+1])
        );
    end

    // Gather column outputs into the carry-save pair (carry is one column up)
    always_comb begin
        cs_nxt                = '0;
        cs_nxt.sum[NCOL-1:0]  = col_sum;
        cs_nxt.carry[PW-1:1]  = col_carry;
    end

    // S2: register the carry-save pair
    always_ff @(posedge clk) begin
        if (s1_adv) s2_cs <= cs_nxt;
    end

    if (PW < MAX_PW) begin : g_hi
        logic unused_cs_hi;
        assign unused_cs_hi = ^{s2_cs.sum[MAX_PW-1:PW], s2_cs.carry[MAX_PW-1:PW]};
    end

    assign res_nxt = s2_cs.sum[PW-1:0] + s2_cs.carry[PW-1:0];

    // S3: final carry-propagate sum, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst)         s3_res <= '0;
        else if (s2_adv) s3_res <= res_nxt;
    end

`ifdef AP_MULT_ERR_MON_EN
    logic [PW-1:0] s2_exact, s3_err;
    logic [31:0]   err_cnt_q;

    // Exact product travels one stage behind the operands, like the CS pair
    always_ff @(posedge clk) begin
        if (s1_adv) s2_exact <= PW'(s1_a) * PW'(s1_b);
    end

    // Error is formed in S3 so it lines up with out_res
    always_ff @(posedge clk) begin
        if (rst)         s3_err <= '0;
        else if (s2_adv) s3_err <= s2_exact - res_nxt;
    end

    // Count delivered results that were inexact, saturating at all ones
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= '0;
        else if (vld_pipe[3] && out_ready && s3_err != '0 && err_cnt_q != '1)
            err_cnt_q <= err_cnt_q + 32'd1;
    end

    assign out_err = s3_err;
    assign err_cnt = err_cnt_q;
`else
    assign out_err = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ap_mult_pipe.sv
// Directed and streaming bench for ap_mult_pipe (WIDTH=12).
module tb_ap_mult_pipe;
    import ap_mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [11:0] in_a, in_b;
    logic [4:0]  in_lvl;
    logic        out_valid, out_ready;
    logic [23:0] out_res, out_err;
    logic [31:0] err_cnt;

    int total = 0;
    int bad   = 0;
    int exp_ecnt = 0;
    int n_out = 0;

    typedef struct {
        logic [23:0] res;
        logic [23:0] err;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    ap_mult_pipe #(.WIDTH(12), .LVL_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_lvl(in_lvl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_err(out_err), .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check any visible output against the
    // scoreboard head, record accepted operands, then advance past the edge.
    task automatic cycle(input bit iv, input logic [11:0] a, input logic [11:0] b,
                         input logic [4:0] l, input logic [23:0] exp_res, input bit ordy,
                         output bit acc, output bit vis);
        exp_t e;
        in_valid = iv; in_a = a; in_b = b; in_lvl = l; out_ready = ordy;
        #1;
        acc = iv && in_ready;
        vis = out_valid;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("extra_out", 64'(out_valid), 64'(0));
            end else begin
                chk("res", 64'(out_res), 64'(q[0].res));
                chk("err", 64'(out_err), 64'(q[0].err));
                if (out_ready) begin
                    if (q[0].err != '0) exp_ecnt++;
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
        if (acc) begin
            e.res = exp_res;
`ifdef AP_MULT_ERR_MON_EN
            e.err = 24'(24'(a) * 24'(b)) - exp_res;
`else
            e.err = '0;
`endif
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Single transaction with a hand-computed result and a latency check
    task automatic send_one(input logic [11:0] a, input logic [11:0] b, input logic [4:0] l,
                            input logic [23:0] exp_res, input string tag);
        bit acc, vis;
        int lat;
        lat = -1;
        cycle(1'b1, a, b, l, exp_res, 1'b1, acc, vis);
        chk({tag, "_acc"}, 64'(acc), 64'(1));
        for (int n = 1; n <= 6; n++) begin
            cycle(1'b0, 'x, 'x, 'x, '0, 1'b1, acc, vis);
            if (vis && lat < 0) lat = n;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(3));
        chk({tag, "_ecnt"}, 64'(err_cnt), 64'(exp_ecnt));
    endtask

    initial begin
        bit          acc, vis;
        int          idx, cyc;
        logic [11:0] ra, rb;
        logic [4:0]  rl;
        logic [63:0] rr;
        int          sent;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_lvl = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ovalid", 64'(out_valid), 64'(0));
        chk("rst_res",    64'(out_res),   64'(0));
        chk("rst_err",    64'(out_err),   64'(0));
        chk("rst_ecnt",   64'(err_cnt),   64'(0));
        chk("rst_irdy",   64'(in_ready),  64'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_irdy", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Hand-computed vectors
        send_one(12'd4095, 12'd4095, 5'd0,  24'd16769025, "exact_max");
        send_one(12'd3,    12'd3,    5'd4,  24'd7,        "k4_3x3");
        send_one(12'd4095, 12'd4095, 5'd31, 24'd8388607,  "sat31");
        rr = ap_mult_ref(32'd4095, 32'd4095, 24, 12);
        send_one(12'd4095, 12'd4095, 5'd24, rr[23:0],     "sat24_ref");
        send_one(12'd5,    12'd6,    5'd2,  24'd30,       "k2_5x6");
        send_one(12'd7,    12'd7,    5'd3,  24'd39,       "k3_7x7");
        send_one(12'd2048, 12'd2048, 5'd22, 24'd4194304,  "top_col");
        send_one(12'd0,    12'd4095, 5'd5,  24'd0,        "zero");
        send_one(12'd4095, 12'd1,    5'd0,  24'd4095,     "one");

        // Backpressure: 5 offered with the consumer stalled, only 3 fit
        idx = 0;
        for (int n = 0; n < 6; n++) begin
            cycle(idx < 5, 12'(idx+1), 12'(idx+2), 5'd0, 24'((idx+1)*(idx+2)), 1'b0, acc, vis);
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'(3));
        #0;
        chk("bp_irdy", 64'(in_ready), 64'(0));
        n_out = 0;
        cyc = 0;
        while ((idx < 5 || q.size() != 0) && cyc < 30) begin
            cycle(idx < 5, 12'(idx+1), 12'(idx+2), 5'd0, 24'((idx+1)*(idx+2)), 1'b1, acc, vis);
            if (acc) idx++;
            cyc++;
        end
        chk("bp_drained", 64'(n_out), 64'(5));
        chk("bp_ecnt", 64'(err_cnt), 64'(exp_ecnt));

        // Streaming with random operands, levels and consumer stalls
        sent = 0;
        n_out = 0;
        cyc = 0;
        ra = 12'($urandom); rb = 12'($urandom); rl = 5'($urandom);
        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            rr = ap_mult_ref(32'(ra), 32'(rb), int'(rl), 12);
            cycle(sent < 10000 && ($urandom_range(3) != 0), ra, rb, rl, rr[23:0],
                  $urandom_range(1) == 1, acc, vis);
            if (acc) begin
                sent++;
                ra = 12'($urandom); rb = 12'($urandom); rl = 5'($urandom);
            end
            cyc++;
        end
        chk("stream_count", 64'(n_out), 64'(10000));
        chk("stream_ecnt",  64'(err_cnt), 64'(exp_ecnt));

        // Reset with the pipeline full
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 12'd3, 12'd3, 5'd4, 24'd7, 1'b0, acc, vis);
            chk("mid_fill", 64'(acc), 64'(1));
        end
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("mid_rst_irdy", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("mid_rst_ovalid", 64'(out_valid), 64'(0));
        chk("mid_rst_ecnt",   64'(err_cnt),   64'(0));
        chk("mid_rst_res",    64'(out_res),   64'(0));
        rst = 1'b0;
        q.delete();
        exp_ecnt = 0;
        send_one(12'd3, 12'd3, 5'd4, 24'd7, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
